// File: rtl/alu_issue_queue.sv
// Issue stage for templatized_alu: buffers requests, issues them with a result-slot credit, returns tagged results.
// Optional flush input enabled by defining ALU_ISSUE_QUEUE_FLUSH_EN.
module alu_issue_queue #(
  parameter int WIDTH     = 32,
  parameter int OP_W      = 4,
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [OP_W-1:0]            in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [OP_W-1:0]            alu_op,
  input  logic [WIDTH-1:0]           alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic [TAG_W-1:0]           res_tag,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int RPW = $clog2(RES_DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int RCW = $clog2(RES_DEPTH+1);

  logic [WIDTH-1:0] r_cmd_a   [DEPTH];
  logic [WIDTH-1:0] r_cmd_b   [DEPTH];
  logic [OP_W-1:0]  r_cmd_op  [DEPTH];
  logic [TAG_W-1:0] r_cmd_tag [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cmd_count;

  logic [WIDTH-1:0] r_res_data [RES_DEPTH];
  logic [TAG_W-1:0] r_res_tag  [RES_DEPTH];
  logic [RPW-1:0]   r_res_wr;
  logic [RPW-1:0]   r_res_rd;
  logic [RCW-1:0]   r_res_count;

  logic             r_pipe_valid;
  logic [TAG_W-1:0] r_pipe_tag;
  logic [OP_W-1:0]  r_alu_op;

  logic             w_flush;
  logic             w_push;
  logic             w_cmd_nonempty;
  logic             w_issue;
  logic             w_res_push;
  logic             w_res_pop;
  logic [RCW:0]     w_credit_sum;

`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign in_ready       = !rst && !w_flush && (r_cmd_count != CW'(DEPTH));
  assign w_push         = in_valid && in_ready;
  assign w_cmd_nonempty = (r_cmd_count != '0);
  assign cmd_count      = rst ? '0 : r_cmd_count;

  // Slots already promised: buffered results minus the one leaving now, plus the op in the ALU.
  assign w_res_pop    = res_valid && res_ready;
  assign w_credit_sum = {1'b0, r_res_count} - {{RCW{1'b0}}, w_res_pop}
                      + {{RCW{1'b0}}, r_pipe_valid};
  assign w_issue      = w_cmd_nonempty && !w_flush && (w_credit_sum < (RCW+1)'(RES_DEPTH));
  assign w_res_push   = r_pipe_valid && !w_flush;

  assign alu_a  = w_cmd_nonempty ? r_cmd_a[r_rd_ptr] : '0;
  assign alu_b  = w_cmd_nonempty ? r_cmd_b[r_rd_ptr] : '0;
  assign alu_op = r_alu_op;

  assign res_valid = !rst && (r_res_count != '0);
  assign res_data  = r_res_data[r_res_rd];
  assign res_tag   = r_res_tag[r_res_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_a[r_wr_ptr]   <= in_a;
      r_cmd_b[r_wr_ptr]   <= in_b;
      r_cmd_op[r_wr_ptr]  <= in_op;
      r_cmd_tag[r_wr_ptr] <= in_tag;
    end
    if (!rst && w_res_push) begin
      r_res_data[r_res_wr] <= alu_out;
      r_res_tag[r_res_wr]  <= r_pipe_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cmd_count  <= '0;
      r_res_wr     <= '0;
      r_res_rd     <= '0;
      r_res_count  <= '0;
      r_pipe_valid <= 1'b0;
      r_pipe_tag   <= '0;
      r_alu_op     <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_cmd_count <= '0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_cmd_count <= r_cmd_count + CW'(w_push) - CW'(w_issue);
      end
      r_pipe_valid <= w_issue;
      if (w_issue) begin
        r_alu_op   <= r_cmd_op[r_rd_ptr];
        r_pipe_tag <= r_cmd_tag[r_rd_ptr];
      end
      if (w_res_push) r_res_wr <= r_res_wr + RPW'(1);
      if (w_res_pop)  r_res_rd <= r_res_rd + RPW'(1);
      r_res_count <= r_res_count + RCW'(w_res_push) - RCW'(w_res_pop);
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU (A/B registered, op combinational, out = A+B+op).
module tb_alu_issue_queue;
  localparam int WIDTH = 32;
  localparam int OP_W  = 4;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int RES_DEPTH = 2;
  localparam int CW = $clog2(DEPTH+1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [TAG_W-1:0] res_tag;
  logic [CW-1:0]    cmd_count;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
  logic             flush;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [TAG_W+WIDTH-1:0] exp_q[$];

  alu_issue_queue #(
    .WIDTH(WIDTH), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .cmd_count(cmd_count)
  );

  // Clock and ALU model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  always @(posedge clk) begin
    m_a <= alu_a;
    m_b <= alu_b;
  end
  assign alu_out = m_a + m_b + WIDTH'(alu_op);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pushes n requests A=base+i, B=3i, op=2, tag=i; expected result base+4i+2.
  task automatic push_n(input int n, input int base);
    int sent = 0;
    int cyc  = 0;
    logic rdy;
    while (sent < n && cyc < 100) begin
      in_valid = 1'b1;
      in_a     = WIDTH'(base + sent);
      in_b     = WIDTH'(3 * sent);
      in_op    = OP_W'(2);
      in_tag   = TAG_W'(sent);
      rdy      = in_ready;
      step();
      if (rdy) begin
        exp_q.push_back({TAG_W'(sent), WIDTH'(base + 4 * sent + 2)});
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("push_count", 32'(sent), 32'(n));
  endtask

  // Stalls the result side and pushes 6: two results buffered, four commands queued.
  task automatic setup_stalled(input int base);
    res_ready = 1'b0;
    push_n(6, base);
    chk("stall_cmd_count", 32'(cmd_count), 32'd4);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [TAG_W+WIDTH-1:0] e;
    int got;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    res_ready = 1'b0;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single op: 5+7+1 = 13, visible in cycle 3 only
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7; in_op = 4'd1; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    chk("single_c1_valid", 32'(res_valid), 32'd0);
    step();
    chk("single_c2_valid", 32'(res_valid), 32'd0);
    step();
    chk("single_c3_valid", 32'(res_valid), 32'd1);
    chk("single_data", res_data, 32'd13);
    chk("single_tag", 32'(res_tag), 32'd3);
    step();
    chk("single_c4_valid", 32'(res_valid), 32'd0);
    chk("single_alu_op_hold", 32'(alu_op), 32'd1);

    // Streaming: push k appears after edge k+2
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_a = WIDTH'(c); in_b = 32'd10; in_op = '0; in_tag = TAG_W'(c);
        chk("stream_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("stream_valid", 32'(res_valid), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9) begin
        chk("stream_data", res_data, 32'(10 + c - 2));
        chk("stream_tag", 32'(res_tag), 32'(c - 2));
      end
    end

    // Backpressure, hold, and full-with-simultaneous-pop
    exp_q.delete();
    setup_stalled(100);
    step(); step();
    chk("hold_valid", 32'(res_valid), 32'd1);
    chk("hold_data", res_data, 32'd102);
    chk("hold_tag", 32'(res_tag), 32'd0);
    res_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    chk("full_pop_count", 32'(cmd_count), 32'd4);
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_extra", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("drain_data", res_data, e[WIDTH-1:0]);
          chk("drain_tag", 32'(res_tag), 32'(e[TAG_W+WIDTH-1:WIDTH]));
        end
        got++;
      end
      step();
      if (cyc == 0) begin
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count", 32'(cmd_count), 32'd3);
      end
    end
    chk("drain_total", 32'(got), 32'd6);
    step(); step();
    chk("drain_no_dup", 32'(res_valid), 32'd0);

    // Reset with 3 queued, 1 in flight, 1 buffered
    exp_q.delete();
    setup_stalled(200);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("mid_cmd_count", 32'(cmd_count), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cmd_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    res_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (res_valid) got++;
    end
    chk("mid_rst_no_results", 32'(got), 32'd0);
    chk("mid_rst_count_idle", 32'(cmd_count), 32'd0);

`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    // Flush: only the buffered result (i=1, 300+4+2) survives
    exp_q.delete();
    setup_stalled(300);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_cmd_count", 32'(cmd_count), 32'd0);
    chk("flush_res_valid", 32'(res_valid), 32'd1);
    chk("flush_res_data", res_data, 32'd306);
    chk("flush_res_tag", 32'(res_tag), 32'd1);
    res_ready = 1'b1;
    #1;
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (res_valid) got++;
      step();
    end
    chk("flush_delivered", 32'(got), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
